// File: rtl/baby_serial_word_tx.sv
// baby_serial_word_tx: parallel-in, serial-out word transmitter.
// A word is accepted over valid/ready and sent LSB first, one bit per clk.
// An even-parity bit follows the last data bit, then an inter-word gap.
//
// state  | meaning
// IDLE   | waiting for a word, load_ready high
// SHIFT  | data bits on serial_out, bit_cnt = index of the bit shown
// PARITY | parity bit on serial_out, parity_valid high
// GAP    | blackout before the next word, gap_cnt counts down to 0
module baby_serial_word_tx #(
  parameter int WORD_WIDTH = 32,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  serial_out,
  output logic                  word_start,
  output logic                  word_end,
  output logic                  parity_valid,
  output logic                  parity_out,
  output logic                  busy
);

  localparam int BW = $clog2(WORD_WIDTH);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_WIDTH - 1);
  localparam logic [BW-1:0] NEXT_LAST = BW'(WORD_WIDTH - 2);
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] shift_reg;
  logic [BW-1:0]         bit_cnt;
  logic [GW-1:0]         gap_cnt;
  logic                  parity_acc;

  // Ready is combinational so a word can be taken in the first cycle reset is low.
  assign load_ready = (state == IDLE) && !reset;

  // Sequencer: state, datapath and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      parity_acc   <= 1'b0;
      serial_out   <= 1'b0;
      word_start   <= 1'b0;
      word_end     <= 1'b0;
      parity_valid <= 1'b0;
      parity_out   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid && load_ready) begin
            // Bit 0 goes straight to the output register; the rest waits in shift_reg.
            state      <= SHIFT;
            shift_reg  <= {1'b0, data_in[WORD_WIDTH-1:1]};
            bit_cnt    <= '0;
            parity_acc <= data_in[0];
            serial_out <= data_in[0];
            word_start <= 1'b1;
            word_end   <= 1'b0;
            busy       <= 1'b1;
          end
        end
        SHIFT: begin
          word_start <= 1'b0;
          if (bit_cnt == LAST_BIT) begin
            state        <= PARITY;
            bit_cnt      <= '0;
            serial_out   <= parity_acc;
            parity_out   <= parity_acc;
            parity_valid <= 1'b1;
            word_end     <= 1'b0;
          end else begin
            bit_cnt    <= bit_cnt + 1'b1;
            serial_out <= shift_reg[0];
            shift_reg  <= {1'b0, shift_reg[WORD_WIDTH-1:1]};
            parity_acc <= parity_acc ^ shift_reg[0];
            word_end   <= (bit_cnt == NEXT_LAST);
          end
        end
        PARITY: begin
          serial_out   <= 1'b0;
          parity_valid <= 1'b0;
          parity_out   <= 1'b0;
          if (GAP_CYCLES > 0) begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
